alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer_pkg.sv | 24 ++
 rtl/alu_cmd_sequencer_if.sv | 47 ++++
 rtl/alu_req_fifo.sv | 34 +++
 rtl/alu_cmd_sequencer.sv | 89 ++++++++
 tb/tb_alu_cmd_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg: opcodes, flag indices, FSM encoding and request record shared by the sequencer.
package alu_cmd_sequencer_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam int FLAG_INVALID     = 4;
    localparam int FLAG_DIV_BY_ZERO = 3;
    localparam int FLAG_OVERFLOW    = 2;
    localparam int FLAG_UNDERFLOW   = 1;
    localparam int FLAG_INEXACT     = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_RESP} state_t;
    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [2:0]  op_code;
        logic        mode_fp;
        logic        round_mode;
    } req_t;
    // Half-precision results only carry meaning in the low 16 bits.
    function automatic logic [31:0] hp_mask(input logic [31:0] r, input logic sp);
        return sp ? r : {16'h0, r[15:0]};
    endfunction
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: request, ALU and response channels of the command sequencer.
interface alu_cmd_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op_a;
    logic [31:0] req_op_b;
    logic [2:0]  req_op_code;
    logic        req_mode_fp;
    logic        req_round_mode;
    logic [31:0] alu_op_a;
    logic [31:0] alu_op_b;
    logic [2:0]  alu_op_code;
    logic        alu_mode_fp;
    logic        alu_round_mode;
    logic        alu_start;
    logic [31:0] alu_result;
    logic        alu_valid_out;
    logic [4:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic        rsp_timeout;
    logic [4:0]  sticky_flags;
    logic        sticky_clr;
    logic        busy;
    modport slave (
        input  req_valid, req_op_a, req_op_b, req_op_code, req_mode_fp, req_round_mode,
        output req_ready,
        output alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode, alu_start,
        input  alu_result, alu_valid_out, alu_flags,
        output rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        input  rsp_ready,
        output sticky_flags, busy,
        input  sticky_clr
    );
    modport master (
        output req_valid, req_op_a, req_op_b, req_op_code, req_mode_fp, req_round_mode,
        input  req_ready,
        input  alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode, alu_start,
        output alu_result, alu_valid_out, alu_flags,
        input  rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        output rsp_ready,
        input  sticky_flags, busy,
        output sticky_clr
    );
endinterface

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: synchronous power-of-two FIFO with wrap-bit pointers and full/empty flags.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU requests, issues them one at a time with timeout, and returns
// each result through a valid/ready response channel with sticky flag accumulation.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                clk,
    input logic                rst,
    alu_cmd_sequencer_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t         state;
    req_t           din;
    req_t           head;
    req_t           cur;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           full;
    logic           empty;
    logic           pop;
    logic           fire_rsp;
    assign din = '{op_a: bus.req_op_a, op_b: bus.req_op_b, op_code: bus.req_op_code,
                   mode_fp: bus.req_mode_fp, round_mode: bus.req_round_mode};
    assign pop      = state == ST_IDLE && !empty;
    assign cnt_nxt  = cnt + CW'(1);
    assign fire_rsp = bus.rsp_valid && bus.rsp_ready;
    alu_req_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(req_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req_valid && !full),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    assign bus.req_ready      = !full;
    assign bus.busy           = state != ST_IDLE || !empty;
    assign bus.alu_op_a       = cur.op_a;
    assign bus.alu_op_b       = cur.op_b;
    assign bus.alu_op_code    = cur.op_code;
    assign bus.alu_mode_fp    = cur.mode_fp;
    assign bus.alu_round_mode = cur.round_mode;
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            cur              <= '0;
            bus.alu_start    <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_flags    <= '0;
            bus.rsp_timeout  <= 1'b0;
            bus.sticky_flags <= '0;
        end else begin
            // A clear coincident with a delivery keeps only that delivery's flags.
            bus.sticky_flags <= (bus.sticky_clr ? 5'b0 : bus.sticky_flags) | (fire_rsp ? bus.rsp_flags : 5'b0);
            case (state)
                ST_IDLE: if (!empty) begin
                    cur           <= head;
                    cnt           <= '0;
                    bus.alu_start <= 1'b1;
                    state         <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    cnt <= cnt_nxt;
                    if (bus.alu_valid_out || cnt_nxt == CW'(TIMEOUT_CYCLES)) begin
                        bus.rsp_result  <= bus.alu_valid_out ? hp_mask(bus.alu_result, cur.mode_fp) : 32'h0;
                        bus.rsp_flags   <= bus.alu_valid_out ? bus.alu_flags : 5'b0;
                        bus.rsp_timeout <= !bus.alu_valid_out;
                        bus.alu_start   <= 1'b0;
                        state           <= ST_DRAIN;
                    end
                end
                ST_DRAIN: if (!bus.alu_valid_out) begin
                    bus.rsp_valid <= 1'b1;
                    state         <= ST_RESP;
                end
                ST_RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed vector table plus hand sequences for fill, timeout, sticky and reset.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    alu_cmd_sequencer_if bus();
    alu_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural ALU: answers lat cycles after seeing start, or never while hang is set.
    int          lat = 3;
    bit          hang = 0;
    bit          use_fixed = 0;
    logic [31:0] fixed_res = '0;
    logic [4:0]  model_flags = '0;
    int          mcnt;
    bit          run;
    always @(posedge clk) begin
        if (rst) begin
            bus.alu_valid_out <= 1'b0;
            bus.alu_result    <= '0;
            bus.alu_flags     <= '0;
            run  <= 0;
            mcnt <= 0;
        end else begin
            bus.alu_valid_out <= 1'b0;
            if (run) begin
                if (mcnt <= 1) begin
                    bus.alu_valid_out <= 1'b1;
                    bus.alu_result    <= use_fixed ? fixed_res : bus.alu_op_a + bus.alu_op_b;
                    bus.alu_flags     <= model_flags;
                    run <= 0;
                end else mcnt <= mcnt - 1;
            end else if (bus.alu_start && !bus.alu_valid_out && !hang) begin
                run  <= 1;
                mcnt <= lat;
            end
        end
    end

    // Monitor: start rise rules, operand stability and ISSUE run length.
    logic        prev_start = 1'b0;
    logic        prev_valid = 1'b0;
    logic [68:0] prev_ops = '0;
    logic [68:0] ops;
    int          gap = 100;
    int          run_len = 0;
    int          last_run = 0;
    assign ops = {bus.alu_op_a, bus.alu_op_b, bus.alu_op_code, bus.alu_mode_fp, bus.alu_round_mode};
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            prev_valid = 1'b0;
            gap = 100;
            run_len = 0;
        end else begin
            if (bus.alu_start && !prev_start) begin
                n_cmp++;
                if (prev_valid || bus.alu_valid_out || gap < 2) begin
                    n_bad++;
                    $display("FAIL start_rise: valid_out %b gap %0d, required valid_out 0 and gap >= 2", prev_valid, gap);
                end
            end
            if (bus.alu_start && prev_start) begin
                n_cmp++;
                if (ops !== prev_ops) begin
                    n_bad++;
                    $display("FAIL op_stable: got %h expected %h", ops, prev_ops);
                end
            end
            if (!bus.alu_start && prev_start) last_run = run_len;
            run_len = bus.alu_start ? run_len + 1 : 0;
            gap = bus.alu_start ? 0 : gap + 1;
            prev_start = bus.alu_start;
            prev_valid = bus.alu_valid_out;
            prev_ops = ops;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic m, input logic r);
        int n = 0;
        bus.req_op_a = a;
        bus.req_op_b = b;
        bus.req_op_code = op;
        bus.req_mode_fp = m;
        bus.req_round_mode = r;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_wait: req_ready stayed %b, required 1", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!bus.rsp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic get_rsp(input string name, input logic [31:0] res, input logic [4:0] fl, input logic to, input logic clr);
        wait_rsp();
        chk({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({name, "_res"}, bus.rsp_result, res);
        chk({name, "_flags"}, 32'(bus.rsp_flags), 32'(fl));
        chk({name, "_timeout"}, 32'(bus.rsp_timeout), 32'(to));
        bus.rsp_ready = 1'b1;
        bus.sticky_clr = clr;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.sticky_clr = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        m;
        logic        r;
        int          lat;
        logic [31:0] res;
        logic [4:0]  fl;
        logic [31:0] exp_res;
    } vec_t;
    vec_t vt[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        vt[0] = '{32'h0000_3C00, 32'h0000_3C00, OP_ADD, 1'b0, 1'b0, 2, 32'hABCD_4000, 5'b00000, 32'h0000_4000};
        vt[1] = '{32'h3F80_0000, 32'h4000_0000, OP_SUB, 1'b1, 1'b0, 1, 32'hBF80_0000, 5'b00001, 32'hBF80_0000};
        vt[2] = '{32'h0000_C000, 32'h0000_4000, OP_MUL, 1'b0, 1'b1, 4, 32'hFFFF_8001, 5'b00100, 32'h0000_8001};
        vt[3] = '{32'h3F80_0000, 32'h0000_0000, OP_DIV, 1'b1, 1'b0, 5, 32'h7F80_0000, 5'b01000, 32'h7F80_0000};
        vt[4] = '{32'h0000_7BFF, 32'h0000_7BFF, OP_ADD, 1'b0, 1'b1, 3, 32'h5A5A_7C00, 5'b10011, 32'h0000_7C00};
        bus.req_valid = 1'b0;
        bus.req_op_a = '0;
        bus.req_op_b = '0;
        bus.req_op_code = '0;
        bus.req_mode_fp = 1'b0;
        bus.req_round_mode = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.sticky_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_alu_start", 32'(bus.alu_start), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sticky", 32'(bus.sticky_flags), 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_alu_op_a", bus.alu_op_a, 32'd0);
        rst = 1'b0;

        // HP add and request-to-issue latency
        use_fixed = 1;
        fixed_res = 32'h1234_4200;
        lat = 3;
        push(32'h0000_4000, 32'h0000_3C00, OP_ADD, 1'b0, 1'b0);
        chk("lat_start_low", 32'(bus.alu_start), 32'd0);
        chk("lat_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("lat_start_high", 32'(bus.alu_start), 32'd1);
        chk("hp_op_a", bus.alu_op_a, 32'h0000_4000);
        chk("hp_op_b", bus.alu_op_b, 32'h0000_3C00);
        get_rsp("hp_add", 32'h0000_4200, 5'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            fixed_res = vt[i].res;
            model_flags = vt[i].fl;
            lat = vt[i].lat;
            push(vt[i].a, vt[i].b, vt[i].op, vt[i].m, vt[i].r);
            @(negedge clk);
            chk($sformatf("v%0d_opcode", i), 32'(bus.alu_op_code), 32'(vt[i].op));
            chk($sformatf("v%0d_round", i), 32'(bus.alu_round_mode), 32'(vt[i].r));
            get_rsp($sformatf("v%0d", i), vt[i].exp_res, vt[i].fl, 1'b0, 1'b0);
        end
        chk("sticky_table", 32'(bus.sticky_flags), 32'h1F);
        bus.sticky_clr = 1'b1;
        @(negedge clk);
        bus.sticky_clr = 1'b0;
        chk("sticky_clr_idle", 32'(bus.sticky_flags), 32'd0);

        // Sticky accumulation and clear coincident with a delivery
        model_flags = 5'b00001;
        push(32'h1, 32'h1, OP_ADD, 1'b1, 1'b0);
        get_rsp("st1", fixed_res, 5'b00001, 1'b0, 1'b0);
        model_flags = 5'b00100;
        push(32'h2, 32'h2, OP_ADD, 1'b1, 1'b0);
        get_rsp("st2", fixed_res, 5'b00100, 1'b0, 1'b0);
        chk("sticky_or", 32'(bus.sticky_flags), 32'h05);
        model_flags = 5'b10000;
        push(32'h3, 32'h3, OP_ADD, 1'b1, 1'b0);
        get_rsp("st3", fixed_res, 5'b10000, 1'b0, 1'b1);
        chk("sticky_clr_deliver", 32'(bus.sticky_flags), 32'h10);

        // Fill: one in flight parked in RESP, four queued, next one stalls
        use_fixed = 0;
        model_flags = 5'b0;
        lat = 2;
        push(32'd100, 32'd1, OP_ADD, 1'b1, 1'b0);
        wait_rsp();
        for (int i = 1; i <= 4; i++) push(32'(100 * i + 100), 32'(i), OP_ADD, 1'b1, 1'b0);
        chk("fill_full", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_op_a = 32'd600;
        bus.req_op_b = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fill_stall", 32'(bus.req_ready), 32'd0);
        end
        get_rsp("fill0", 32'd101, 5'b0, 1'b0, 1'b0);
        chk("fill_still_full", 32'(bus.req_ready), 32'd0);
        push(32'd600, 32'd5, OP_ADD, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) get_rsp($sformatf("fill%0d", i), 32'(100 * i + 100 + i), 5'b0, 1'b0, 1'b0);

        // Timeout followed by a normally answered request
        hang = 1;
        model_flags = 5'b11111;
        push(32'hDEAD_0000, 32'h1, OP_DIV, 1'b1, 1'b0);
        push(32'd7, 32'd8, OP_ADD, 1'b1, 1'b0);
        wait_rsp();
        chk("to_issue_cycles", 32'(last_run), 32'(TO));
        hang = 0;
        model_flags = 5'b0;
        get_rsp("timeout", 32'h0, 5'b0, 1'b1, 1'b0);
        get_rsp("after_to", 32'd15, 5'b0, 1'b0, 1'b0);

        // Reset while an operation is issuing
        lat = 10;
        push(32'd40, 32'd2, OP_ADD, 1'b1, 1'b0);
        push(32'd50, 32'd3, OP_ADD, 1'b1, 1'b0);
        chk("mid_issue_start", 32'(bus.alu_start), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_alu_start", 32'(bus.alu_start), 32'd0);
        chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mr_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_alu_op_a", bus.alu_op_a, 32'd0);
        chk("mr_sticky", 32'(bus.sticky_flags), 32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.alu_start) seen++;
        end
        chk("mr_no_activity", 32'(seen), 32'd0);
        lat = 2;
        push(32'hFFFF_0001, 32'd2, OP_ADD, 1'b0, 1'b0);
        get_rsp("recover", 32'h0000_0003, 5'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
